io_tx_ctrl: RTL

Memory-mapped I/O output controller. It sits directly downstream of the CPU's external memory bus (`mem_a`/`mem_dout`/`mem_wr`), alongside the RAM. It decodes accesses to the I/O window and buffers output bytes in a FIFO, which it serializes onto an 8N1 UART tx line. It also generates the CPU's `io_buffer_full` back-pressure, serves the clock-counter read at 0x30004 and signals program stop.

---
 rtl/io_tx_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/io_tx_ctrl.sv
// Memory-mapped I/O output controller: decodes the 0x3xxxx I/O window, queues output
// bytes in a small FIFO and serializes them as 8N1 UART frames; also serves the cycle counter.
module io_tx_ctrl #(
    parameter int FIFO_AW      = 3,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  io_rd_data,
    output logic        io_buffer_full,
    output logic        tx,
    output logic        prog_stop,
    output logic        overflow
);

    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int DEPTH_M1 = DEPTH - 1;
    localparam int BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BAUD_MAX = CLKS_PER_BIT - 1;
    localparam logic [BW-1:0]    BAUD_LAST = BAUD_MAX[BW-1:0];
    localparam logic [FIFO_AW:0] CNT_FULL  = DEPTH[FIFO_AW:0];
    localparam logic [FIFO_AW:0] CNT_HIGH  = DEPTH_M1[FIFO_AW:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    logic               acc_s, wr_out_s, wr_stop_s, rd_cnt_s;
    logic               push_req_s, push_s, pop_s, stop_done_s;
    logic [7:0]         push_data_s;
    logic [7:0]         fifo_mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [31:0]        cyc_r, snap_r;
    logic               stop_pend_r;
    tx_state_t          state_r, state_s;
    logic [BW-1:0]      baud_r, baud_s;
    logic [2:0]         idx_r, idx_s;
    logic [7:0]         shift_r, shift_s;
    logic               tx_s;
    logic               unused_addr_s;

    assign unused_addr_s = ^{mem_a[31:18], mem_a[15:3]};

    assign acc_s       = rdy_in && (mem_a[17:16] == 2'b11);
    assign wr_out_s    = acc_s && mem_wr && (mem_a[2:0] == 3'd0);
    assign wr_stop_s   = acc_s && mem_wr && (mem_a[2:0] == 3'd4);
    assign rd_cnt_s    = acc_s && !mem_wr && mem_a[2];
    // A zero byte to the data port is swallowed; the stop port always enqueues a 0x00 terminator.
    assign push_req_s  = (wr_out_s && (mem_dout != 8'h00)) || wr_stop_s;
    assign push_data_s = wr_stop_s ? 8'h00 : mem_dout;
    assign push_s      = push_req_s && (count_r != CNT_FULL);

    // One slot of margin covers a CPU write already in flight when it samples the flag.
    assign io_buffer_full = (count_r >= CNT_HIGH);

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) fifo_mem_r[i] <= 8'h00;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r             <= wr_ptr_r + 1'b1;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky status flags
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            overflow    <= 1'b0;
            stop_pend_r <= 1'b0;
            prog_stop   <= 1'b0;
        end else begin
            if (push_req_s && (count_r == CNT_FULL)) overflow <= 1'b1;
            if (wr_stop_s) stop_pend_r <= 1'b1;
            if (stop_done_s && stop_pend_r) prog_stop <= 1'b1;
        end
    end

    // Cycle counter, snapshot and registered read data
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cyc_r      <= 32'd0;
            snap_r     <= 32'd0;
            io_rd_data <= 8'h00;
        end else if (rdy_in) begin
            cyc_r <= cyc_r + 32'd1;
            if (rd_cnt_s) begin
                case (mem_a[1:0])
                    2'd0: begin
                        snap_r     <= cyc_r;
                        io_rd_data <= cyc_r[7:0];
                    end
                    2'd1:    io_rd_data <= snap_r[15:8];
                    2'd2:    io_rd_data <= snap_r[23:16];
                    default: io_rd_data <= snap_r[31:24];
                endcase
            end else begin
                io_rd_data <= 8'h00;
            end
        end
    end

    // Transmitter state register; tx is registered from the current state so it lags the FSM by one cycle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            tx      <= 1'b1;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            tx      <= tx_s;
        end
    end

    // Transmitter next-state logic; STOP pops directly into START so frames run back to back
    always_comb begin
        state_s     = state_r;
        baud_s      = baud_r;
        idx_s       = idx_r;
        shift_s     = shift_r;
        pop_s       = 1'b0;
        stop_done_s = 1'b0;
        tx_s        = 1'b1;
        case (state_r)
            ST_IDLE: begin
                tx_s = 1'b1;
                if (count_r != '0) begin
                    pop_s   = 1'b1;
                    shift_s = fifo_mem_r[rd_ptr_r];
                    baud_s  = '0;
                    state_s = ST_START;
                end else begin
                    baud_s = '0;
                end
            end
            ST_START: begin
                tx_s = 1'b0;
                if (baud_r == BAUD_LAST) begin
                    baud_s  = '0;
                    idx_s   = 3'd0;
                    state_s = ST_DATA;
                end else begin
                    baud_s = baud_r + 1'b1;
                end
            end
            ST_DATA: begin
                tx_s = shift_r[idx_r];
                if (baud_r == BAUD_LAST) begin
                    baud_s = '0;
                    if (idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + 1'b1;
                end
            end
            ST_STOP: begin
                tx_s = 1'b1;
                if (baud_r == BAUD_LAST) begin
                    baud_s = '0;
                    if (count_r != '0) begin
                        pop_s   = 1'b1;
                        shift_s = fifo_mem_r[rd_ptr_r];
                        state_s = ST_START;
                    end else begin
                        stop_done_s = 1'b1;
                        state_s     = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_r + 1'b1;
                end
            end
            default: begin
                tx_s    = 1'b1;
                baud_s  = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

endmodule
